// File: rtl/spim_xfer_ctrl.sv
// Word-level SPI mode-0 master: streams command words out MSB-first on the SPIM pins and returns
// the captured MISO word; chip select is held across chained words until a LAST word completes.
module spim_xfer_ctrl #(
  parameter int DATA_W   = 8,
  parameter int CLKDIV   = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [DATA_W-1:0] CMD_DATA,
  input  logic              CMD_LAST,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic              BUSY,
  output logic              SPIM_CLK,
  output logic              SPIM_MOSI,
  input  logic              SPIM_MISO,
  output logic              SPIM_SS_N
);

  localparam int MAX_T = (CLKDIV > CS_SETUP) ? ((CLKDIV > CS_HOLD) ? CLKDIV : CS_HOLD)
                                             : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int CNT_W = $clog2(MAX_T + 1);
  localparam int BIT_W = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLKDIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
  localparam logic [BIT_W-1:0] BIT_LD   = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    SHIFT_LO  = 3'd2,
    SHIFT_HI  = 3'd3,
    WORD_DONE = 3'd4,
    HOLD      = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              last_q, last_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              ss_n_q, ss_n_d;
  logic              rv_q, rv_d;
  logic              ready;
  logic              accept;
  logic              cnt_done;

  // WORD_DONE only takes a new word once the previous response is gone or leaving this cycle.
  always_comb begin
    ready = 1'b0;
    case (state_q)
      IDLE:      ready = 1'b1;
      WORD_DONE: ready = !rv_q || RSP_READY;
      default:   ready = 1'b0;
    endcase
    ready = ready && !RST;
  end

  assign accept   = CMD_VALID && ready;
  assign cnt_done = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    last_d  = last_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    ss_n_d  = ss_n_q;
    rv_d    = rv_q;

    if (rv_q && RSP_READY) rv_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          tx_d    = CMD_DATA;
          last_d  = CMD_LAST;
          mosi_d  = CMD_DATA[DATA_W-1];
          ss_n_d  = 1'b0;
          bit_d   = BIT_LD;
          cnt_d   = SETUP_LD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_done) begin
          cnt_d   = DIV_LD;
          state_d = SHIFT_LO;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SHIFT_LO: begin
        if (cnt_done) begin
          sck_d   = 1'b1;
          rx_d    = {rx_q[DATA_W-2:0], SPIM_MISO};
          cnt_d   = DIV_LD;
          state_d = SHIFT_HI;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SHIFT_HI: begin
        if (cnt_done) begin
          sck_d = 1'b0;
          if (bit_q != '0) begin
            bit_d   = bit_q - BIT_W'(1);
            tx_d    = tx_q << 1;
            mosi_d  = tx_q[DATA_W-2];
            cnt_d   = DIV_LD;
            state_d = SHIFT_LO;
          end else begin
            rd_d = rx_q;
            rv_d = 1'b1;
            if (last_q) begin
              cnt_d   = HOLD_LD;
              state_d = HOLD;
            end else begin
              state_d = WORD_DONE;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WORD_DONE: begin
        // Chained word skips SETUP: chip select is already low.
        if (accept) begin
          tx_d    = CMD_DATA;
          last_d  = CMD_LAST;
          mosi_d  = CMD_DATA[DATA_W-1];
          bit_d   = BIT_LD;
          cnt_d   = DIV_LD;
          state_d = SHIFT_LO;
        end
      end
      HOLD: begin
        if (cnt_done) begin
          ss_n_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rd_q    <= '0;
      last_q  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      last_q  <= last_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      ss_n_q  <= ss_n_d;
      rv_q    <= rv_d;
    end
  end

  assign CMD_READY = ready;
  assign RSP_VALID = rv_q;
  assign RSP_DATA  = rd_q;
  assign BUSY      = (state_q != IDLE);
  assign SPIM_CLK  = sck_q;
  assign SPIM_MOSI = mosi_q;
  assign SPIM_SS_N = ss_n_q;

endmodule

// File: tb/tb_spim_xfer_ctrl.sv
// Bench for spim_xfer_ctrl: table-driven single-word transfers, directed chain/stall/reset/ignore
// sequences, and random framed traffic checked against a queue-based word-level model.
module tb_spim_xfer_ctrl;
  localparam int DW  = 8;
  localparam int CD  = 2;
  localparam int CSS = 1;
  localparam int CSH = 1;
  localparam int T_RSP = 1 + CSS + 2 * CD * DW;

  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_last = 1'b0;
  logic [DW-1:0] cmd_data = '0, rsp_data;
  logic rsp_valid, rsp_ready = 1'b1, busy, sck, mosi, miso, ss_n;
  logic loop = 1'b0, miso_drv = 1'b0, rand_on = 1'b0;

  assign miso = loop ? mosi : miso_drv;

  always #5 clk = ~clk;

  spim_xfer_ctrl #(.DATA_W(DW), .CLKDIV(CD), .CS_SETUP(CSS), .CS_HOLD(CSH)) dut (
    .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_DATA(cmd_data),
    .CMD_LAST(cmd_last), .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data),
    .BUSY(busy), .SPIM_CLK(sck), .SPIM_MOSI(mosi), .SPIM_MISO(miso), .SPIM_SS_N(ss_n)
  );

  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Word-level reference: expected MOSI words, expected responses, MISO word per transfer.
  logic [DW-1:0] exp_mosi[$], exp_rsp[$], miso_plan[$];
  int acc_cyc = 0, acc_n = 0, ss_fall_cyc = 0, ss_rise_cyc = 0, ss_rise_n = 0;
  int first_rise_cyc = 0, last_rise_cyc = 0, rise_n = 0, rsp_set_cyc = 0, busy_fall_cyc = 0;
  int per_bad = 0, ss_bad = 0, riw = 0;
  bit waiting = 0;
  logic [DW-1:0] mosi_acc = '0;
  logic prev_ss = 1'b1, prev_sck = 1'b0, prev_rv = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      riw = 0; mosi_acc = '0; waiting = 0;
      exp_mosi.delete(); exp_rsp.delete(); miso_plan.delete();
    end else begin
      if (cmd_valid && cmd_ready) begin acc_cyc = cyc; acc_n++; waiting = 1; end
      if (prev_ss && !ss_n) begin ss_fall_cyc = cyc; rise_n = 0; end
      if (!prev_ss && ss_n) begin ss_rise_cyc = cyc; ss_rise_n++; end
      if (prev_busy && !busy) busy_fall_cyc = cyc;
      if (!prev_rv && rsp_valid) rsp_set_cyc = cyc;
      if (!prev_sck && sck) begin
        if (riw > 0 && (cyc - last_rise_cyc) != 2 * CD) per_bad++;
        if (waiting) begin first_rise_cyc = cyc; waiting = 0; end
        if (ss_n) ss_bad++;
        last_rise_cyc = cyc;
        rise_n++;
        mosi_acc = {mosi_acc[DW-2:0], mosi};
        riw++;
        if (riw == DW) begin
          riw = 0;
          if (exp_mosi.size() == 0) chk("mosi_unexpected_word", 32'(mosi_acc), 32'hFFFF_FFFF);
          else chk("mosi_word", 32'(mosi_acc), 32'(exp_mosi.pop_front()));
          if (miso_plan.size() > 0) void'(miso_plan.pop_front());
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 32'(rsp_data), 32'hFFFF_FFFF);
        else chk("rsp_data", 32'(rsp_data), 32'(exp_rsp.pop_front()));
      end
      miso_drv = (miso_plan.size() > 0) ? miso_plan[0][DW-1-riw] : 1'b0;
    end
    prev_ss = ss_n; prev_sck = sck; prev_rv = rsp_valid; prev_busy = busy;
  end

  always @(posedge clk) if (rand_on) begin
    #1 rsp_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic drive_cmd(input logic [DW-1:0] d, input logic l);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_data = d; cmd_last = l;
  endtask

  task automatic wait_acc(output int t);
    bit got = 0;
    t = cyc;
    for (int n = 0; n < 2000 && !got; n++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1; t = cyc; end
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit got = 0;
    for (int n = 0; n < 2000 && !got; n++) begin
      @(negedge clk);
      if (!busy) got = 1;
    end
    if (!got) chk("idle_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp_drain();
    for (int n = 0; n < 4000 && exp_rsp.size() != 0; n++) @(negedge clk);
    if (exp_rsp.size() != 0) chk("drain_timeout", 32'(exp_rsp.size()), 32'd0);
  endtask

  typedef struct {
    logic [DW-1:0] cmd;
    logic          lp;
    logic [DW-1:0] miso;
    logic [DW-1:0] rsp;
  } vec_t;

  vec_t vt[5];

  initial begin
    int t, t1, t2, a0, rn, bad, k;
    logic [DW-1:0] hold, d, m;
    logic p;

    vt[0] = '{cmd: 8'hA5, lp: 1'b1, miso: 8'h00, rsp: 8'hA5};
    vt[1] = '{cmd: 8'hFF, lp: 1'b0, miso: 8'h5A, rsp: 8'h5A};
    vt[2] = '{cmd: 8'h3C, lp: 1'b1, miso: 8'h00, rsp: 8'h3C};
    vt[3] = '{cmd: 8'h00, lp: 1'b0, miso: 8'hFF, rsp: 8'hFF};
    vt[4] = '{cmd: 8'h81, lp: 1'b0, miso: 8'h42, rsp: 8'h42};

    repeat (3) @(negedge clk);
    chk("rst_ss_n", 32'(ss_n), 32'd1);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;

    // Single LAST words: timing and data.
    for (int i = 0; i < 5; i++) begin
      loop = vt[i].lp;
      exp_mosi.push_back(vt[i].cmd);
      exp_rsp.push_back(vt[i].rsp);
      miso_plan.push_back(vt[i].miso);
      drive_cmd(vt[i].cmd, 1'b1);
      wait_acc(t);
      wait_idle();
      chk($sformatf("v%0d_ss_fall", i), 32'(ss_fall_cyc - t), 32'd1);
      chk($sformatf("v%0d_first_rise", i), 32'(first_rise_cyc - t), 32'(1 + CSS + CD));
      chk($sformatf("v%0d_sck_pulses", i), 32'(rise_n), 32'(DW));
      chk($sformatf("v%0d_rsp_valid_at", i), 32'(rsp_set_cyc - t), 32'(T_RSP));
      chk($sformatf("v%0d_ss_rise", i), 32'(ss_rise_cyc - t), 32'(T_RSP + CSH));
      chk($sformatf("v%0d_busy_fall", i), 32'(busy_fall_cyc - t), 32'(T_RSP + CSH));
    end

    // Chained pair with immediate response consumption.
    loop = 1'b1; rsp_ready = 1'b1;
    exp_mosi.push_back(8'h3C); exp_rsp.push_back(8'h3C); miso_plan.push_back(8'h00);
    exp_mosi.push_back(8'hC3); exp_rsp.push_back(8'hC3); miso_plan.push_back(8'h00);
    rn = ss_rise_n;
    drive_cmd(8'h3C, 1'b0);
    wait_acc(t1);
    drive_cmd(8'hC3, 1'b1);
    wait_acc(t2);
    wait_idle();
    chk("chain_second_accept", 32'(t2 - t1), 32'(T_RSP));
    chk("chain_second_first_rise", 32'(first_rise_cyc - t2), 32'(CD + 1));
    chk("chain_sck_pulses", 32'(rise_n), 32'(2 * DW));
    chk("chain_ss_single_rise", 32'(ss_rise_n - rn), 32'd1);
    chk("chain_ss_rise", 32'(ss_rise_cyc - t2), 32'(2 * CD * DW + 1 + CSH));

    // Chained pair stalled on an unconsumed response.
    loop = 1'b0; rsp_ready = 1'b0;
    exp_mosi.push_back(8'h3C); exp_rsp.push_back(8'h11); miso_plan.push_back(8'h11);
    exp_mosi.push_back(8'hC3); exp_rsp.push_back(8'h22); miso_plan.push_back(8'h22);
    drive_cmd(8'h3C, 1'b0);
    wait_acc(t1);
    drive_cmd(8'hC3, 1'b1);
    for (int n = 0; n < 200 && !rsp_valid; n++) @(negedge clk);
    hold = rsp_data;
    a0 = acc_n;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0 || sck !== 1'b0 || ss_n !== 1'b0 || rsp_valid !== 1'b1 ||
          rsp_data !== hold) bad++;
    end
    chk("stall_bad_cycles", 32'(bad), 32'd0);
    chk("stall_no_accept", 32'(acc_n - a0), 32'd0);
    chk("stall_rsp_data", 32'(rsp_data), 32'h11);
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_acc(t2);
    wait_idle();
    chk("stall_release_first_rise", 32'(first_rise_cyc - t2), 32'(CD + 1));

    // Reset during SHIFT_HI of bit 4, then a fresh transfer.
    loop = 1'b1;
    exp_mosi.push_back(8'hA5); exp_rsp.push_back(8'hA5); miso_plan.push_back(8'h00);
    drive_cmd(8'hA5, 1'b1);
    wait_acc(t);
    k = 0; p = sck;
    for (int n = 0; n < 200 && k < 4; n++) begin
      @(negedge clk);
      if (sck && !p) k++;
      p = sck;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ss_n", 32'(ss_n), 32'd1);
    chk("midrst_sck", 32'(sck), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    exp_mosi.push_back(8'h96); exp_rsp.push_back(8'h96); miso_plan.push_back(8'h00);
    drive_cmd(8'h96, 1'b1);
    wait_acc(t);
    wait_idle();
    chk("post_rst_rsp_valid_at", 32'(rsp_set_cyc - t), 32'(T_RSP));
    chk("post_rst_ss_rise", 32'(ss_rise_cyc - t), 32'(T_RSP + CSH));

    // CMD_VALID pulse during SHIFT_LO must be ignored.
    exp_mosi.push_back(8'h5A); exp_rsp.push_back(8'h5A); miso_plan.push_back(8'h00);
    drive_cmd(8'h5A, 1'b1);
    wait_acc(t);
    a0 = acc_n;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_data = 8'hFF; cmd_last = 1'b1;
    @(negedge clk);
    chk("ignore_sck_low", 32'(sck), 32'd0);
    chk("ignore_ready_low", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    chk("ignore_no_second", 32'(acc_n - a0), 32'd0);
    chk("ignore_busy_low", 32'(busy), 32'd0);

    // Random framed traffic with random response back-pressure.
    loop = 1'b0;
    rand_on = 1'b1;
    for (int f = 0; f < 12; f++) begin
      int nw;
      wait_rsp_drain();
      @(posedge clk); #2;
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) begin
        d = 8'($urandom);
        m = 8'($urandom);
        exp_mosi.push_back(d); exp_rsp.push_back(m); miso_plan.push_back(m);
        drive_cmd(d, (w == nw - 1));
        wait_acc(t);
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #2;
      end
    end
    wait_rsp_drain();
    rand_on = 1'b0;
    @(posedge clk); #2 rsp_ready = 1'b1;
    wait_idle();

    chk("exp_rsp_left", 32'(exp_rsp.size()), 32'd0);
    chk("exp_mosi_left", 32'(exp_mosi.size()), 32'd0);
    chk("sck_period_bad", 32'(per_bad), 32'd0);
    chk("ss_high_at_sck_rise", 32'(ss_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
